// File: rtl/div_restoring_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// iteration counter sizing.
package div_restoring_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Counter must hold 0..w-1 with headroom for the increment on the last step.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/addsub_nbit.sv
// Parameterised N-bit ripple-carry adder/subtractor: s = a + (b ^ {N{s_op}}) + cin.
// Purely combinational; cout is the carry out of the msb (1 = no borrow when subtracting).
module addsub_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         s_op,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0]   carry;
    logic [N-1:0] b_x;

    assign carry[0] = cin;
    assign b_x      = b ^ {N{s_op}};

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]       = a[i] ^ b_x[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/div_restoring_seq.sv
// Unsigned restoring divider, one trial subtraction per clock; W+1 cycles from
// accepted start to done (1 cycle for a zero divisor). start is ignored while busy.
module div_restoring_seq
    import div_restoring_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(W);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  q_out_q, q_out_d;
    logic [W-1:0]  r_out_q, r_out_d;
    logic          dbz_q, dbz_d;

    logic [W:0]    trial_a;
    logic [W:0]    trial_b;
    logic [W:0]    trial_s;
    logic          trial_cout;
    logic          no_borrow;
    logic [W-1:0]  rem_step;
    logic [W-1:0]  quo_step;

    assign trial_a = {rem_q, quo_q[W-1]};
    assign trial_b = {1'b0, dvs_q};

    addsub_nbit #(
        .N (W + 1)
    ) u_addsub (
        .a    (trial_a),
        .b    (trial_b),
        .cin  (1'b1),
        .s_op (1'b1),
        .s    (trial_s),
        .cout (trial_cout)
    );

    // A successful trial always leaves a difference below the divisor, so its
    // msb is zero; folding it in keeps the whole W+1-bit result accounted for.
    assign no_borrow = trial_cout & ~trial_s[W];
    assign rem_step  = no_borrow ? trial_s[W-1:0] : trial_a[W-1:0];
    assign quo_step  = {quo_q[W-2:0], no_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        q_out_d = '1;
                        r_out_d = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = dividend;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                // Results are published only on the final step.
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_DONE;
                    q_out_d = quo_step;
                    r_out_d = rem_step;
                    dbz_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = q_out_q;
    assign remainder   = r_out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Directed and exhaustive checks of the W=4 restoring divider.
module tb_div_restoring_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    div_restoring_seq #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle; returns 1 time unit after the sampling edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // n = edge index (counted from the edge before start was raised) at which
    // done is seen; bc = number of busy samples before that.
    task automatic wait_done(input int n0, output int n, output int bc);
        n  = n0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                            input int elat, input int ebusy, input bit hold);
        int n;
        int bc;
        bit held;
        launch(a, b);
        wait_done(1, n, bc);
        check({tag, " latency"}, n, elat);
        check({tag, " busy cycles"}, bc, ebusy);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, div_by_zero, ez);
        @(posedge clk); #1;
        check({tag, " done pulse width"}, done, 1'b0);
        if (hold) begin
            held = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (quotient !== eq || remainder !== er || done !== 1'b0) held = 1'b0;
                @(posedge clk); #1;
            end
            check({tag, " hold 10 cycles"}, held, 1'b1);
        end
    endtask

    initial begin
        int  n;
        int  bc;
        bit  saw_done;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 4'h0);
        check("reset remainder", remainder, 4'h0);
        check("reset div_by_zero", div_by_zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Divide by zero: single-cycle path, busy never asserted.
        run_case("9/0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1, 0, 1'b1);

        // Reset mid-RUN clears outputs asynchronously and produces no done.
        launch(4'd13, 4'd3);
        check("13/3 busy before reset", busy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun reset busy", busy, 1'b0);
        check("midrun reset done", done, 1'b0);
        check("midrun reset quotient", quotient, 4'h0);
        check("midrun reset remainder", remainder, 4'h0);
        check("midrun reset div_by_zero", div_by_zero, 1'b0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("midrun reset no done", saw_done, 1'b0);
        run_case("13/3 after reset", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, W + 1, W, 1'b0);

        // Boundaries with result hold.
        run_case("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, W + 1, W, 1'b1);
        run_case("0/7",  4'd0,  4'd7, 4'd0,  4'd0, 1'b0, W + 1, W, 1'b1);
        run_case("6/15", 4'd6,  4'd15, 4'd0, 4'd6, 1'b0, W + 1, W, 1'b1);

        // start during RUN must be ignored.
        launch(4'd15, 4'd2);
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_done(2, n, bc);
        check("ignored start latency", n, W + 1);
        check("ignored start quotient", quotient, 4'd7);
        check("ignored start remainder", remainder, 4'd1);

        // Back-to-back: start held through DONE picks up new operands.
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd4;
        @(posedge clk); #1;
        wait_done(1, n, bc);
        check("b2b first latency", n, W + 1);
        check("b2b first quotient", quotient, 4'd3);
        check("b2b first remainder", remainder, 4'd3);
        dividend = 4'd8;
        divisor  = 4'd8;
        @(posedge clk); #1;
        start    = 1'b0;
        check("b2b restart busy", busy, 1'b1);
        check("b2b held first quotient", quotient, 4'd3);
        wait_done(1, n, bc);
        check("b2b second latency", n, W + 1);
        check("b2b second quotient", quotient, 4'd1);
        check("b2b second remainder", remainder, 4'd0);
        @(posedge clk); #1;

        // Exhaustive sweep against a behavioural reference.
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 16; a++) begin
                run_case($sformatf("%0d/%0d", a, b), W'(a), W'(b), W'(a / b), W'(a % b),
                         1'b0, W + 1, W, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
